// File: rtl/unpadder_if.sv
// Stream interface for the unpadder: padded words in, de-padded words plus sideband out.
// The slave modport is the unpadder's view; the master modport is the environment's view.
interface unpadder_if;
  logic [63:0] pin;
  logic        pin_valid;
  logic        pin_last;
  logic        pin_ready;
  logic [63:0] pout;
  logic [3:0]  bytenum;
  logic        pout_last;
  logic        pout_err;
  logic [15:0] wordidx;
  logic        pout_valid;
  logic        pout_ready;

  modport slave (
    input  pin, pin_valid, pin_last, pout_ready,
    output pin_ready, pout, bytenum, pout_last, pout_err, wordidx, pout_valid
  );

  modport master (
    output pin, pin_valid, pin_last, pout_ready,
    input  pin_ready, pout, bytenum, pout_last, pout_err, wordidx, pout_valid
  );
endinterface

// File: rtl/unpadder.sv
// Strips the 0x40 pad marker and trailing zero bytes from the last word of a message,
// through a single-entry, one-cycle-latency output register with a per-message word index.
module unpadder (
  input  logic      clk,
  input  logic      reset,
  unpadder_if.slave bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      state, state_next;
  logic        in_xfer, out_xfer;

  logic [2:0]  pad_pos;
  logic [7:0]  pad_byte;
  logic        pad_found;
  logic [63:0] dec_word;
  logic [3:0]  dec_bytes;
  logic        dec_err;

  logic [15:0] cnt;
  logic [63:0] pout_q;
  logic [3:0]  bytes_q;
  logic        last_q;
  logic        err_q;
  logic [15:0] idx_q;

  assign bus.pin_ready = (state == EMPTY) || bus.pout_ready;
  assign in_xfer       = bus.pin_valid && bus.pin_ready;
  assign out_xfer      = (state == HOLD) && bus.pout_ready;

  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    state_next = state;
    case (state)
      EMPTY:   if (in_xfer) state_next = HOLD;
      HOLD:    if (out_xfer && !in_xfer) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  // Ascending scan: the last hit is the highest-numbered nonzero byte.
  always_comb begin
    pad_pos   = 3'd0;
    pad_byte  = 8'h00;
    pad_found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.pin[63-8*i -: 8] != 8'h00) begin
        pad_pos   = 3'(i);
        pad_byte  = bus.pin[63-8*i -: 8];
        pad_found = 1'b1;
      end
    end
  end

  always_comb begin
    dec_word  = bus.pin;
    dec_bytes = 4'd8;
    dec_err   = 1'b0;
    if (bus.pin_last) begin
      if (pad_found && pad_byte == 8'h40) begin
        for (int i = 0; i < 8; i++) begin
          if (3'(i) >= pad_pos) dec_word[63-8*i -: 8] = 8'h00;
        end
        dec_bytes = {1'b0, pad_pos};
      end else begin
        // Malformed pad still emits a word so the downstream sees the message end.
        dec_word  = 64'h0;
        dec_bytes = 4'd0;
        dec_err   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state   <= EMPTY;
      pout_q  <= 64'h0;
      bytes_q <= 4'd0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= 16'd0;
      cnt     <= 16'd0;
    end else begin
      state <= state_next;
      if (in_xfer) begin
        pout_q  <= dec_word;
        bytes_q <= dec_bytes;
        last_q  <= bus.pin_last;
        err_q   <= dec_err;
        idx_q   <= cnt;
        if (bus.pin_last)        cnt <= 16'd0;
        else if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;
      end
    end
  end

  assign bus.pout       = pout_q;
  assign bus.bytenum    = bytes_q;
  assign bus.pout_last  = last_q;
  assign bus.pout_err   = err_q;
  assign bus.wordidx    = idx_q;
  assign bus.pout_valid = (state == HOLD);

endmodule

// File: tb/tb_unpadder.sv
// Self-checking bench for unpadder: directed vector table, hand-written multi-cycle sequences,
// and a randomized stream scored against a byte-level reference model.
module tb_unpadder;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  bytes;
    logic        last;
    logic        err;
    logic [15:0] idx;
  } beat_t;

  typedef struct {
    logic [63:0] word;
    logic        last;
    logic [63:0] exp_data;
    logic [3:0]  exp_bytes;
    logic        exp_err;
    logic [15:0] exp_idx;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  unpadder_if bus();

  unpadder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_beat(input string name, input beat_t e);
    check({name, ".valid"}, 64'(bus.pout_valid), 64'd1);
    check({name, ".pout"},  bus.pout,            e.data);
    check({name, ".bytes"}, 64'(bus.bytenum),    64'(e.bytes));
    check({name, ".last"},  64'(bus.pout_last),  64'(e.last));
    check({name, ".err"},   64'(bus.pout_err),   64'(e.err));
    check({name, ".idx"},   64'(bus.wordidx),    64'(e.idx));
  endtask

  // Reference: find the highest nonzero byte by scanning down, then mask with a shift.
  function automatic beat_t model(input logic [63:0] w, input logic last, input int idx);
    beat_t b;
    int    p;
    b.last = last;
    b.idx  = 16'((idx > 65535) ? 65535 : idx);
    if (!last) begin
      b.data = w; b.bytes = 4'd8; b.err = 1'b0;
      return b;
    end
    p = -1;
    for (int k = 7; k >= 0; k--)
      if (p < 0 && w[63-8*k -: 8] != 8'h00) p = k;
    if (p >= 0 && w[63-8*p -: 8] == 8'h40) begin
      b.data  = w & ~({64{1'b1}} >> (8*p));
      b.bytes = 4'(p);
      b.err   = 1'b0;
    end else begin
      b.data = 64'h0; b.bytes = 4'd0; b.err = 1'b1;
    end
    return b;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [63:0] gen_last_word();
    int p;
    case ($urandom_range(0, 3))
      0:       return 64'h0;
      1:       return rand64();
      default: begin
        p = $urandom_range(0, 7);
        return (rand64() & ~({64{1'b1}} >> (8*p))) | (64'h40 << (56 - 8*p));
      end
    endcase
  endfunction

  task automatic do_reset();
    bus.pin_valid = 1'b0;
    bus.pin_last  = 1'b0;
    bus.pin       = 64'h0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  vec_t  vecs[11];
  beat_t exp_q[$];
  beat_t e;
  int    mcnt;

  initial begin
    vecs[0]  = '{64'h4000_0000_0000_0000, 1'b1, 64'h0,                   4'd0, 1'b0, 16'd0};
    vecs[1]  = '{64'h1122_3344_5566_7780, 1'b1, 64'h0,                   4'd0, 1'b1, 16'd0};
    vecs[2]  = '{64'h0,                   1'b1, 64'h0,                   4'd0, 1'b1, 16'd0};
    vecs[3]  = '{64'h0102_0304_0506_4000, 1'b1, 64'h0102_0304_0506_0000, 4'd6, 1'b0, 16'd0};
    vecs[4]  = '{64'hDEAD_BEEF_0102_0304, 1'b0, 64'hDEAD_BEEF_0102_0304, 4'd8, 1'b0, 16'd0};
    vecs[5]  = '{64'h0,                   1'b0, 64'h0,                   4'd8, 1'b0, 16'd1};
    vecs[6]  = '{64'h1122_3344_5566_7740, 1'b1, 64'h1122_3344_5566_7700, 4'd7, 1'b0, 16'd2};
    vecs[7]  = '{64'h4040_4040_4040_4040, 1'b1, 64'h4040_4040_4040_4000, 4'd7, 1'b0, 16'd0};
    vecs[8]  = '{64'h1200_0000_0000_0000, 1'b1, 64'h0,                   4'd0, 1'b1, 16'd0};
    vecs[9]  = '{64'h4000_0000_0000_0041, 1'b1, 64'h0,                   4'd0, 1'b1, 16'd0};
    vecs[10] = '{64'h0000_0040_0000_0000, 1'b1, 64'h0,                   4'd3, 1'b0, 16'd0};

    // Reset state, with pout_ready low so pin_ready must come from the EMPTY state.
    bus.pout_ready = 1'b0;
    reset = 1'b1;
    bus.pin_valid = 1'b0;
    bus.pin_last  = 1'b0;
    bus.pin       = 64'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.valid", 64'(bus.pout_valid), 64'd0);
    check("rst.ready", 64'(bus.pin_ready),  64'd1);
    check("rst.pout",  bus.pout,            64'h0);
    check("rst.bytes", 64'(bus.bytenum),    64'd0);
    check("rst.last",  64'(bus.pout_last),  64'd0);
    check("rst.err",   64'(bus.pout_err),   64'd0);
    check("rst.idx",   64'(bus.wordidx),    64'd0);
    reset = 1'b0;

    // Directed vector table, one word at a time.
    bus.pout_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      bus.pin = vecs[i].word; bus.pin_last = vecs[i].last; bus.pin_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.pin_valid = 1'b0;
      e = '{vecs[i].exp_data, vecs[i].exp_bytes, vecs[i].last, vecs[i].exp_err, vecs[i].exp_idx};
      check_beat($sformatf("vec%0d", i), e);
    end
    @(negedge clk);
    check("vec.drained", 64'(bus.pout_valid), 64'd0);

    // Two full words then a padded last word, streamed back to back.
    begin
      logic [63:0] ws[3];
      beat_t       es[3];
      ws[0] = 64'h0011_2233_4455_6677; ws[1] = 64'h8899_AABB_CCDD_EEFF; ws[2] = 64'hAABB_CC40_0000_0000;
      es[0] = '{ws[0], 4'd8, 1'b0, 1'b0, 16'd0};
      es[1] = '{ws[1], 4'd8, 1'b0, 1'b0, 16'd1};
      es[2] = '{64'hAABB_CC00_0000_0000, 4'd3, 1'b1, 1'b0, 16'd2};
      for (int i = 0; i < 3; i++) begin
        bus.pin = ws[i]; bus.pin_last = (i == 2); bus.pin_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_beat($sformatf("msg3_%0d", i), es[i]);
      end
      bus.pin_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("msg3.drained", 64'(bus.pout_valid), 64'd0);
    end

    // Back-pressure: one word held for 5 cycles, then the stream drains in order.
    bus.pout_ready = 1'b0;
    bus.pin = 64'h1111_1111_1111_1111; bus.pin_last = 1'b0; bus.pin_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.pin = 64'h2222_2222_2222_2222;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp%0d.ready", c), 64'(bus.pin_ready), 64'd0);
      check_beat($sformatf("bp%0d", c), '{64'h1111_1111_1111_1111, 4'd8, 1'b0, 1'b0, 16'd0});
      @(posedge clk);
      @(negedge clk);
    end
    bus.pout_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_beat("bp.w1", '{64'h2222_2222_2222_2222, 4'd8, 1'b0, 1'b0, 16'd1});
    bus.pin = 64'h3333_4000_0000_0000; bus.pin_last = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_beat("bp.w2", '{64'h3333_0000_0000_0000, 4'd2, 1'b1, 1'b0, 16'd2});
    bus.pin_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("bp.drained", 64'(bus.pout_valid), 64'd0);

    // Reset mid-message while HOLD: valid drops without a clock edge, position restarts.
    bus.pout_ready = 1'b0;
    bus.pin = 64'h5555_5555_5555_5555; bus.pin_last = 1'b0; bus.pin_valid = 1'b1;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst.valid", 64'(bus.pout_valid), 64'd0);
    check("arst.ready", 64'(bus.pin_ready),  64'd1);
    check("arst.idx",   64'(bus.wordidx),    64'd0);
    check("arst.pout",  bus.pout,            64'h0);
    @(negedge clk);
    bus.pin_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    bus.pout_ready = 1'b1;
    bus.pin = 64'h0102_0304_0506_4000; bus.pin_last = 1'b1; bus.pin_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.pin_valid = 1'b0;
    check_beat("arst.next", '{64'h0102_0304_0506_0000, 4'd6, 1'b1, 1'b0, 16'd0});

    // Oversized message: index saturates at 0xFFFF, last word keeps it, next message restarts.
    @(negedge clk);
    bus.pin = 64'hCAFE_F00D_1234_5678; bus.pin_valid = 1'b1;
    for (int n = 0; n <= 65538; n++) begin
      bus.pin_last = (n == 65537);
      @(posedge clk);
      @(negedge clk);
      if (n >= 65534 && n <= 65536)
        check($sformatf("sat%0d.idx", n), 64'(bus.wordidx), 64'd65535 - 64'(n < 65535 ? 65535 - n : 0));
      else if (n == 65537)
        check_beat("sat.last", '{64'h0, 4'd0, 1'b1, 1'b1, 16'hFFFF});
      else if (n == 65538)
        check("sat.restart.idx", 64'(bus.wordidx), 64'd0);
    end
    bus.pin_valid = 1'b0;

    // Randomized stream against the reference model.
    do_reset();
    mcnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [63:0] w;
      logic        l;
      @(negedge clk);
      l = ($urandom_range(0, 3) == 0);
      w = l ? gen_last_word() : rand64();
      bus.pin = w; bus.pin_last = l;
      bus.pin_valid  = ($urandom_range(0, 3) != 0);
      bus.pout_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (bus.pout_valid && bus.pout_ready) begin
        if (exp_q.size() == 0) check("rand.spurious", 64'd1, 64'd0);
        else check_beat("rand", exp_q.pop_front());
      end
      if (bus.pin_valid && bus.pin_ready) begin
        exp_q.push_back(model(w, l, mcnt));
        mcnt = l ? 0 : ((mcnt < 65535) ? mcnt + 1 : 65535);
      end
    end
    @(negedge clk);
    bus.pin_valid = 1'b0;
    bus.pout_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (bus.pout_valid) begin
        if (exp_q.size() == 0) check("drain.spurious", 64'd1, 64'd0);
        else check_beat("drain", exp_q.pop_front());
      end
      @(negedge clk);
    end
    check("rand.leftover", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/unpadder.md
UNPADDER -- requirements
Module: unpadder

Interface
REQ-001 The block SHALL be a single-clock design with a stream-in / stream-out valid-ready interface; there are no parameters, and all widths below are fixed.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 pin  input  64  padded message word; byte 0 = pin[63:56], byte k = pin[63-8k -: 8].
REQ-005 pin_valid  input  1  pin/pin_last are valid this cycle.
REQ-006 pin_last  input  1  pin is the final (padded) word of the message.
REQ-007 pin_ready  output  1  block accepts pin this cycle.
REQ-008 pout  output  64  de-padded word; pad and trailing bytes are forced to zero.
REQ-009 bytenum  output  4  count of message bytes in pout, 0..8.
REQ-010 pout_last  output  1  pout is the final word of the message.
REQ-011 pout_err  output  1  the final word carried malformed padding.
REQ-012 wordidx  output  16  zero-based index of pout within its message.
REQ-013 pout_valid  output  1  pout and its sideband are valid.
REQ-014 pout_ready  input  1  downstream accepts pout this cycle.

Function
REQ-015 A transfer SHALL occur on any edge where valid and ready are both high, on either side.
REQ-016 The FSM SHALL have two states: EMPTY (no word held) and HOLD (one word held, pout_valid=1).
REQ-017 pin_ready SHALL be (state==EMPTY) | pout_ready, combinational, so a sustained stream moves 1 word/cycle.
REQ-018 Latency SHALL be 1 cycle: a word accepted at edge N is presented on pout after edge N.
REQ-019 Transitions: EMPTY→HOLD on an input transfer; HOLD→EMPTY on an output transfer with no input transfer; HOLD→HOLD on simultaneous input and output transfers, with the register reloaded from pin.
REQ-020 With pout_valid=1 and pout_ready=0, pout and all sideband outputs SHALL hold stable.
REQ-021 Non-last word: pout=pin, bytenum=8, pout_last=0, pout_err=0.
REQ-022 Last word: let p be the index of the highest-numbered nonzero byte (bytes p+1..7 all zero).
REQ-023 Last word, valid padding (p exists and byte p==8'h40): bytes 0..p-1 pass unchanged, bytes p..7 are output as zero, bytenum=p, pout_last=1, pout_err=0.
REQ-024 Last word, malformed padding (all bytes zero, or byte p!=8'h40): pout=0, bytenum=0, pout_last=1, pout_err=1. The word is still emitted, so message framing is preserved.
REQ-025 A last word whose pad is at byte 0 (pin=64'h4000_0000_0000_0000) SHALL produce bytenum=0, pout_last=1, pout_err=0; this is the pad-only word that follows a full 8-byte message word.
REQ-026 The word counter SHALL advance on every input transfer: wordidx of the loaded word = counter value; counter increments on non-last words and clears to 0 after a last word.
REQ-027 The counter SHALL saturate at 16'hFFFF and keep that value for the remaining words of an oversized message.
REQ-028 Decode SHALL be computed from pin at the input transfer and registered; outputs SHALL be driven only from registers, except pin_ready.

Reset
REQ-029 While reset=1, and immediately on its assertion: state=EMPTY, pout=0, bytenum=0, pout_last=0, pout_err=0, wordidx=0, pout_valid=0, word counter=0.
REQ-030 Reset asserted mid-message SHALL discard the held word and the message position; the first word accepted after release has wordidx=0.
REQ-031 pin_ready SHALL be 1 during and after reset, following REQ-017 with state=EMPTY.

Verification
REQ-032 Message of 2 full words then last pin=64'hAABBCC40_00000000, pout_ready=1 throughout → three pout beats with wordidx 0,1,2; last beat pout=64'hAABBCC00_00000000, bytenum=3, pout_last=1, pout_err=0.
REQ-033 Single last word pin=64'h40000000_00000000 → pout=0, bytenum=0, pout_last=1, pout_err=0, wordidx=0.
REQ-034 Last word pin=64'h11223344_55667780 (byte 7 = 8'h80) → pout=0, bytenum=0, pout_last=1, pout_err=1; an all-zero last word gives the same response.
REQ-035 Back-pressure: pout_ready=0 for 5 cycles while pin_valid=1 → one word held stable, pin_ready=0, no word lost or duplicated; on release, words drain at 1 per cycle in order.
REQ-036 Last word 64'h01020304_05064000 → bytenum=6, pout=64'h01020304_05060000.
REQ-037 reset pulsed while state=HOLD mid-message → pout_valid drops asynchronously; next message starts at wordidx=0 with correct decode.
